// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: debug command and status bundle between the VIO/ILA side and the run-control sequencer.
// The halt_cnt signal exists only when RUN_CTRL_HALT_CNT_EN is defined.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 16
);
    logic               run_i;
    logic               halt_i;
    logic               step_i;
    logic               burst_i;
    logic [BURST_W-1:0] burst_len;
    logic               bp_en;
    logic [31:0]        bp_addr;
    logic [31:0]        pc_i;
    logic               cpu_enable;
    logic [1:0]         state_o;
    logic               bp_hit;
    logic [CNT_W-1:0]   retired_cnt;
`ifdef RUN_CTRL_HALT_CNT_EN
    logic [CNT_W-1:0]   halt_cnt;
`endif

    // Command source (VIO / bench) side
    modport master (
`ifdef RUN_CTRL_HALT_CNT_EN
        input  halt_cnt,
`endif
        output run_i, halt_i, step_i, burst_i, burst_len, bp_en, bp_addr, pc_i,
        input  cpu_enable, state_o, bp_hit, retired_cnt
    );

    // Sequencer side
    modport slave (
`ifdef RUN_CTRL_HALT_CNT_EN
        output halt_cnt,
`endif
        input  run_i, halt_i, step_i, burst_i, burst_len, bp_en, bp_addr, pc_i,
        output cpu_enable, state_o, bp_hit, retired_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: turns run/halt/step/burst debug commands into the core's per-cycle enable,
// with a PC breakpoint and retired counter. Define RUN_CTRL_HALT_CNT_EN to add halt_cnt.
module cpu_run_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               skip_bp_q, skip_bp_d;
    logic               bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]   retired_q;
    logic               run_prev, step_prev, burst_prev;
    logic               run_rise, step_rise, burst_rise;
    logic               active, bp_match, cpu_enable_c, start;

    // Prev regs reset high so a command held through reset is not seen as an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_prev   <= 1'b1;
            step_prev  <= 1'b1;
            burst_prev <= 1'b1;
        end else begin
            run_prev   <= bus.run_i;
            step_prev  <= bus.step_i;
            burst_prev <= bus.burst_i;
        end
    end

    assign run_rise   = bus.run_i   & ~run_prev;
    assign step_rise  = bus.step_i  & ~step_prev;
    assign burst_rise = bus.burst_i & ~burst_prev;

    // Breakpoint blocks the enable in the same cycle, so the instruction at bp_addr never retires
    assign active       = (state_q != ST_HALT);
    assign bp_match     = active & bus.bp_en & (bus.pc_i == bus.bp_addr) & ~skip_bp_q;
    assign cpu_enable_c = active & ~bp_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HALT;
            burst_cnt_q <= '0;
            skip_bp_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            skip_bp_q   <= skip_bp_d;
            bp_hit_q    <= bp_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        skip_bp_d   = skip_bp_q;
        bp_hit_d    = bp_hit_q;
        start       = 1'b0;

        if (cpu_enable_c) begin
            skip_bp_d = 1'b0;
        end
        if (bp_match) begin
            bp_hit_d = 1'b1;
        end

        unique case (state_q)
            ST_HALT: begin
                // halt_i swallows any edge seen while it is high
                if (!bus.halt_i) begin
                    if (step_rise) begin
                        state_d = ST_STEP;
                        start   = 1'b1;
                    end else if (burst_rise && (bus.burst_len != '0)) begin
                        state_d     = ST_BURST;
                        burst_cnt_d = bus.burst_len;
                        start       = 1'b1;
                    end else if (run_rise) begin
                        state_d = ST_RUN;
                        start   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bp_match || bus.halt_i || !bus.run_i) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_BURST: begin
                if (bp_match || bus.halt_i || (burst_cnt_q == BURST_W'(1))) begin
                    state_d     = ST_HALT;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q - BURST_W'(1);
                end
            end
            default: state_d = ST_HALT;
        endcase

        if (start) begin
            skip_bp_d = 1'b1;
            bp_hit_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (cpu_enable_c) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

`ifdef RUN_CTRL_HALT_CNT_EN
    logic [CNT_W-1:0] halt_cnt_q;

    // Includes cycles parked on a breakpoint
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_cnt_q <= '0;
        end else if (state_q == ST_HALT) begin
            halt_cnt_q <= halt_cnt_q + CNT_W'(1);
        end
    end

    assign bus.halt_cnt = halt_cnt_q;
`endif

    assign bus.cpu_enable  = cpu_enable_c;
    assign bus.state_o     = state_q;
    assign bus.bp_hit      = bp_hit_q;
    assign bus.retired_cnt = retired_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed stimulus against an instruction-budget model of the run controller,
// plus a toy core whose PC advances by 4 on each enabled cycle.
module tb_cpu_run_ctrl;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned BURST_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] pc;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    cpu_run_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Toy core: one instruction per enabled cycle
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= 32'h0;
        else if (bus.cpu_enable) pc <= pc + 32'd4;
    end
    assign bus.pc_i = pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: kind 0 idle, 1 run (unbounded), 2 step, 3 burst; 'left' = instructions still allowed
    int          m_kind;
    int          m_left;
    bit          m_fresh;
    bit          m_bp_hit;
    logic [31:0] m_retired;
    logic [31:0] m_halt_cnt;
    bit          p_run, p_step, p_burst;

    function automatic bit m_bp_block();
        return (m_kind != 0) && bus.bp_en && (bus.pc_i == bus.bp_addr) && !m_fresh;
    endfunction

    function automatic bit m_enable();
        return (m_kind != 0) && !m_bp_block();
    endfunction

    task automatic m_begin(input int kind, input int budget);
        m_kind   = kind;
        m_left   = budget;
        m_fresh  = 1'b1;
        m_bp_hit = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_kind = 0; m_left = 0; m_fresh = 0; m_bp_hit = 0;
            m_retired = 0; m_halt_cnt = 0;
            p_run = 1; p_step = 1; p_burst = 1;
        end else begin
            bit en, blk, r_run, r_step, r_burst;
            en  = m_enable();
            blk = m_bp_block();
            r_run   = bus.run_i   && !p_run;
            r_step  = bus.step_i  && !p_step;
            r_burst = bus.burst_i && !p_burst;
            if (m_kind == 0) m_halt_cnt++;
            if (en) begin
                m_retired++;
                m_fresh = 1'b0;
            end
            if (m_kind == 0) begin
                if (!bus.halt_i) begin
                    if (r_step) m_begin(2, 1);
                    else if (r_burst && bus.burst_len != 0) m_begin(3, int'(bus.burst_len));
                    else if (r_run) m_begin(1, -1);
                end
            end else if (blk) begin
                m_bp_hit = 1'b1;
                m_kind   = 0;
            end else if (bus.halt_i || (m_kind == 1 && !bus.run_i)) begin
                m_kind = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_kind = 0;
            end
            p_run = bus.run_i; p_step = bus.step_i; p_burst = bus.burst_i;
        end
    end

    // Mid-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("cpu_enable", 64'(bus.cpu_enable), 64'(m_enable()));
            check("state_o", 64'(bus.state_o), 64'(m_kind));
            check("bp_hit", 64'(bus.bp_hit), 64'(m_bp_hit));
            check("retired_cnt", 64'(bus.retired_cnt), 64'(m_retired));
`ifdef RUN_CTRL_HALT_CNT_EN
            check("halt_cnt", 64'(bus.halt_cnt), 64'(m_halt_cnt));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.run_i = 1'b1; bus.halt_i = 1'b0; bus.step_i = 1'b0; bus.burst_i = 1'b0;
        bus.burst_len = '0; bus.bp_en = 1'b0; bus.bp_addr = 32'h0;

        // run_i held high across reset release must not start
        cyc(3);
        rst = 1'b0;
        #1;
        check("reset_state", 64'(bus.state_o), 64'd0);
        check("reset_enable", 64'(bus.cpu_enable), 64'd0);
        check("reset_bp_hit", 64'(bus.bp_hit), 64'd0);
        cyc(5);
        check("held_run_state", 64'(bus.state_o), 64'd0);
        check("held_run_retired", 64'(bus.retired_cnt), 64'd0);

        // RUN on rise, stop on run_i low
        bus.run_i = 1'b0;
        cyc(1);
        bus.run_i = 1'b1;
        cyc(1);
        check("run_state", 64'(bus.state_o), 64'd1);
        check("run_enable", 64'(bus.cpu_enable), 64'd1);
        cyc(4);
        check("run_retired4", 64'(bus.retired_cnt), 64'd4);
        bus.run_i = 1'b0;
        cyc(1);
        check("run_stop_state", 64'(bus.state_o), 64'd0);
        check("run_stop_enable", 64'(bus.cpu_enable), 64'd0);
        check("run_stop_retired", 64'(bus.retired_cnt), 64'd5);

        // Three single steps
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.step_i = 1'b1;
            cyc(1);
            bus.step_i = 1'b0;
            cyc(2);
        end
        check("step_retired", 64'(bus.retired_cnt), 64'd3);
        check("step_pc", 64'(pc), 64'h0C);
        check("step_state", 64'(bus.state_o), 64'd0);

        // Burst of 5, then a zero-length burst that must be ignored
        bus.burst_len = 16'd5;
        bus.burst_i = 1'b1;
        cyc(1);
        bus.burst_i = 1'b0;
        cyc(8);
        check("burst5_retired", 64'(bus.retired_cnt), 64'd8);
        check("burst5_state", 64'(bus.state_o), 64'd0);
        bus.burst_len = 16'd0;
        bus.burst_i = 1'b1;
        cyc(1);
        check("burst0_state", 64'(bus.state_o), 64'd0);
        check("burst0_enable", 64'(bus.cpu_enable), 64'd0);
        bus.burst_i = 1'b0;
        cyc(3);
        check("burst0_retired", 64'(bus.retired_cnt), 64'd8);

        // Breakpoint at 0x10, then resume past it
        do_reset();
        bus.bp_en = 1'b1;
        bus.bp_addr = 32'h10;
        bus.run_i = 1'b1;
        cyc(1);
        cyc(10);
        check("bp_pc", 64'(pc), 64'h10);
        check("bp_hit_set", 64'(bus.bp_hit), 64'd1);
        check("bp_retired", 64'(bus.retired_cnt), 64'd4);
        check("bp_state", 64'(bus.state_o), 64'd0);
        bus.run_i = 1'b0;
        cyc(1);
        bus.run_i = 1'b1;
        cyc(1);
        check("bp_resume_enable", 64'(bus.cpu_enable), 64'd1);
        check("bp_hit_cleared", 64'(bus.bp_hit), 64'd0);
        cyc(1);
        check("bp_resume_pc", 64'(pc), 64'h14);
        check("bp_resume_retired", 64'(bus.retired_cnt), 64'd5);
        bus.run_i = 1'b0;
        cyc(2);
        bus.bp_en = 1'b0;

        // halt_i cuts a 100-long burst after 10 instructions
        do_reset();
        bus.burst_len = 16'd100;
        bus.burst_i = 1'b1;
        cyc(1);
        bus.burst_i = 1'b0;
        cyc(9);
        bus.halt_i = 1'b1;
        cyc(1);
        check("halt_burst_retired", 64'(bus.retired_cnt), 64'd10);
        check("halt_burst_state", 64'(bus.state_o), 64'd0);
        cyc(3);
        check("halt_burst_hold", 64'(bus.retired_cnt), 64'd10);

        // A step edge seen while halt_i is high is dropped, not queued
        bus.step_i = 1'b1;
        cyc(1);
        check("halt_step_state", 64'(bus.state_o), 64'd0);
        bus.halt_i = 1'b0;
        cyc(2);
        bus.step_i = 1'b0;
        check("halt_step_lost", 64'(bus.retired_cnt), 64'd10);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
